dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: the backing array holds 2^DEPTH_LOG2 64-bit words.
REQ-002 Parameter LATENCY, default 2 (legal range 1..15): cycles from acceptance to completion.
REQ-003 clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 opstore_index_valid  input  1  store request valid.
REQ-006 opstore_index  input  19  store word index.
REQ-007 opstore_index_ready  output  1  store request may be accepted.
REQ-008 opstore_write_mask  input  64  per-bit write enable.
REQ-009 opstore_write_data  input  64  store data.
REQ-010 opstore_operation_done  output  1  one-cycle store-complete pulse.
REQ-011 opload_index_valid  input  1  load request valid.
REQ-012 opload_index  input  19  load word index.
REQ-013 opload_index_ready  output  1  load request may be accepted.
REQ-014 opload_read_data  output  64  load result.
REQ-015 opload_operation_done  output  1  one-cycle load-complete pulse.

Function
REQ-016 States: IDLE, BUSY, DONE; both ready outputs = (state==IDLE), combinational from state.
REQ-017 Handshake: a request is accepted on a rising edge where its valid and ready are both 1; only one transaction is outstanding at a time.
REQ-018 Arbitration: if both valids are high in IDLE, the store is accepted; the load stays pending and is accepted on the next IDLE cycle.
REQ-019 On acceptance: latch the operation type, index[DEPTH_LOG2-1:0], mask and data; load the counter with LATENCY-1; go to BUSY.
REQ-020 Index bits above DEPTH_LOG2-1 are ignored, so out-of-range indices alias.
REQ-021 BUSY: counter==0 -> DONE, else decrement; requester inputs are not sampled during BUSY or DONE.
REQ-022 On the BUSY->DONE edge, a store writes mem = (mem & ~mask) | (data & mask); a mask of zero leaves the word unchanged.
REQ-023 On the BUSY->DONE edge, a load captures the addressed word, including every earlier completed store, into opload_read_data.
REQ-024 DONE: the matching done output is 1 for exactly this one cycle; the other done output stays 0; next state is IDLE.
REQ-025 Latency: accept at edge E; done is high in the cycle after edge E+LATENCY; ready is high again after edge E+LATENCY+1.
REQ-026 opload_read_data holds its value until the next load completes; stores never alter it.

Reset
REQ-027 Reset values: state IDLE, both readys 1, both dones 0, opload_read_data 0, counter 0.
REQ-028 A reset asserted mid-transaction aborts it: no array write, no done pulse.
REQ-029 Array contents are not reset.

Configuration
REQ-030 Macro DMEM_RESPONDER_STAT_EN defined: add outputs load_count[31:0] and store_count[31:0], reset to 0, each incremented on its done pulse and wrapping 0xFFFFFFFF -> 0.
REQ-031 Macro DMEM_RESPONDER_STAT_EN undefined: those ports and counters do not exist; all other behaviour is identical.

Verification
REQ-032 LATENCY=2: store idx 5, mask all-ones, data 0x1122334455667788 accepted at edge E -> store done high in the cycle after E+2; ready low for 3 cycles.
REQ-033 Load idx 5 following REQ-032 -> load done pulse, opload_read_data = 0x1122334455667788, value held after the pulse.
REQ-034 Store idx 5, mask 0x00000000FFFFFFFF, data 0xAAAAAAAABBBBBBBB, then load idx 5 -> read 0x11223344BBBBBBBB.
REQ-035 Store and load valid in the same IDLE cycle -> store done first; the load is accepted after it and returns the stored data.
REQ-036 reset_n low during BUSY of a store to idx 7 over prior value 0x0 -> no done pulse; a later load of idx 7 returns 0x0.
REQ-037 DEPTH_LOG2=10: load idx 0x00405 returns the value stored at idx 0x005 (aliasing); with DMEM_RESPONDER_STAT_EN, counters match the counts of done pulses.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a store port
// and a load port sharing one 64-bit wide backing array.
//
// Handshake: a request is taken on a rising clock edge where its *_valid and
// *_ready are both 1. Both ready outputs are 1 only in IDLE. Once a request
// is taken the requester inputs are ignored until the responder returns to
// IDLE. Completion is a one-cycle *_operation_done pulse, with no back-pressure.
// When both valids are high in IDLE the store wins. The load remains pending
// and is taken on the next IDLE cycle.
//
// Optional feature: define DMEM_RESPONDER_STAT_EN to add the wrapping 32-bit
// completion counters load_count and store_count.
//
// The current FSM state is exposed on dbg_state_o for checkers.

module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,  // array holds 2**DEPTH_LOG2 words
  parameter int LATENCY    = 2    // accept-to-complete cycles, 1..15
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        opstore_index_valid,
  input  logic [18:0] opstore_index,
  output logic        opstore_index_ready,
  input  logic [63:0] opstore_write_mask,
  input  logic [63:0] opstore_write_data,
  output logic        opstore_operation_done,

  input  logic        opload_index_valid,
  input  logic [18:0] opload_index,
  output logic        opload_index_ready,
  output logic [63:0] opload_read_data,
  output logic        opload_operation_done,

`ifdef DMEM_RESPONDER_STAT_EN
  output logic [31:0] load_count,
  output logic [31:0] store_count,
`endif

  output logic [1:0]  dbg_state_o
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  // Counter is loaded with LATENCY-1 on acceptance. Counting down to zero in
  // BUSY then gives exactly LATENCY edges from acceptance to entering DONE.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    is_store_q, is_store_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [63:0]             mask_q, mask_d;
  logic [63:0]             data_q, data_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [63:0]             rdata_q;

  logic                    mem_we;
  logic                    rd_capture;

  // Backing array. It is intentionally not reset.
  logic [63:0]             mem_q [0:WORDS-1];

  // Index bits above the array size are dropped, so out-of-range indices
  // alias onto the array. Those bits are collected here only to show that
  // they are deliberately unused.
  generate
    if (DEPTH_LOG2 < 19) begin : g_alias
      logic unused_idx_hi;
      assign unused_idx_hi = ^{opstore_index[18:DEPTH_LOG2],
                               opload_index[18:DEPTH_LOG2]};
    end
  endgenerate

  // Next-state logic: accept in IDLE (store has priority), count down in
  // BUSY, and complete the array access on the BUSY->DONE edge.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    mem_we     = 1'b0;
    rd_capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (opstore_index_valid) begin
          is_store_d = 1'b1;
          idx_d      = opstore_index[DEPTH_LOG2-1:0];
          mask_d     = opstore_write_mask;
          data_d     = opstore_write_data;
          cnt_d      = CNT_INIT;
          state_d    = ST_BUSY;
        end else if (opload_index_valid) begin
          is_store_d = 1'b0;
          idx_d      = opload_index[DEPTH_LOG2-1:0];
          cnt_d      = CNT_INIT;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_DONE;
          mem_we     = is_store_q;
          rd_capture = ~is_store_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and transaction registers. An asynchronous reset returns to IDLE,
  // which also cancels any pending array write or load capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      idx_q      <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
    end
  end

  // Load result register. It changes only when a load completes and holds
  // its value across any number of stores.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (rd_capture) begin
      rdata_q <= mem_q[idx_q];
    end
  end

  // Masked array write. Bits with a zero mask keep their old value.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[idx_q] <= (mem_q[idx_q] & ~mask_q) | (data_q & mask_q);
    end
  end

`ifdef DMEM_RESPONDER_STAT_EN
  // Completion counters. Each counts its own done pulses and wraps naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      load_count  <= 32'd0;
      store_count <= 32'd0;
    end else begin
      if (opload_operation_done) begin
        load_count <= load_count + 32'd1;
      end
      if (opstore_operation_done) begin
        store_count <= store_count + 32'd1;
      end
    end
  end
`endif

  assign opstore_index_ready    = (state_q == ST_IDLE);
  assign opload_index_ready     = (state_q == ST_IDLE);
  assign opstore_operation_done = (state_q == ST_DONE) &  is_store_q;
  assign opload_operation_done  = (state_q == ST_DONE) & ~is_store_q;
  assign opload_read_data       = rdata_q;
  assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed cases followed by randomized store
// and load traffic. Results are compared against a word-array reference model
// and a queue of expected load data.

module tb_dmem_responder;

  localparam int DEPTH_LOG2 = 10;
  localparam int LATENCY    = 2;
  localparam int WORDS      = 1 << DEPTH_LOG2;

  // ---------------- clock / reset ----------------
  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;

  always #5 clock = ~clock;

  logic        opstore_index_valid = 1'b0;
  logic [18:0] opstore_index       = '0;
  logic        opstore_index_ready;
  logic [63:0] opstore_write_mask  = '0;
  logic [63:0] opstore_write_data  = '0;
  logic        opstore_operation_done;
  logic        opload_index_valid  = 1'b0;
  logic [18:0] opload_index        = '0;
  logic        opload_index_ready;
  logic [63:0] opload_read_data;
  logic        opload_operation_done;
  logic [1:0]  dbg_state;
`ifdef DMEM_RESPONDER_STAT_EN
  logic [31:0] load_count;
  logic [31:0] store_count;
`endif

  dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .opstore_index_valid    (opstore_index_valid),
    .opstore_index          (opstore_index),
    .opstore_index_ready    (opstore_index_ready),
    .opstore_write_mask     (opstore_write_mask),
    .opstore_write_data     (opstore_write_data),
    .opstore_operation_done (opstore_operation_done),
    .opload_index_valid     (opload_index_valid),
    .opload_index           (opload_index),
    .opload_index_ready     (opload_index_ready),
    .opload_read_data       (opload_read_data),
    .opload_operation_done  (opload_operation_done),
`ifdef DMEM_RESPONDER_STAT_EN
    .load_count             (load_count),
    .store_count            (store_count),
`endif
    .dbg_state_o            (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] mem_m [WORDS];   // reference copy of the array
  logic [63:0] exp_q[$];        // expected data of loads in flight
  logic [63:0] rdata_exp = '0;  // value opload_read_data must hold
  int          exp_store_cnt = 0;
  int          exp_load_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_hold();
    if (!opload_operation_done) check("rdata_hold", opload_read_data, rdata_exp);
  endtask

  task automatic check_stats();
`ifdef DMEM_RESPONDER_STAT_EN
    check("store_count", 64'(store_count), 64'(exp_store_cnt));
    check("load_count", 64'(load_count), 64'(exp_load_cnt));
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Each is called at a falling edge while the DUT is idle.
  task automatic start_store(input logic [18:0] idx, input logic [63:0] mask, input logic [63:0] data);
    logic [DEPTH_LOG2-1:0] w;
    w = idx[DEPTH_LOG2-1:0];
    opstore_index_valid = 1'b1;
    opstore_index       = idx;
    opstore_write_mask  = mask;
    opstore_write_data  = data;
    mem_m[w] = (mem_m[w] & ~mask) | (data & mask);
  endtask

  task automatic start_load(input logic [18:0] idx);
    logic [DEPTH_LOG2-1:0] w;
    w = idx[DEPTH_LOG2-1:0];
    opload_index_valid = 1'b1;
    opload_index       = idx;
    exp_q.push_back(mem_m[w]);
  endtask

  // Let the pending request be accepted at the next rising edge. Follow it to
  // its done pulse, checking latency, readies, the other done and the data,
  // and return at the falling edge of the following idle cycle.
  task automatic finish_op(input bit st);
    int   k;
    bit   seen;
    logic done_v, other_v;
    @(posedge clock);
    @(negedge clock);
    if (st) opstore_index_valid = 1'b0;
    else    opload_index_valid  = 1'b0;
    k    = 1;
    seen = 1'b0;
    while (!seen && k <= 40) begin
      done_v  = st ? opstore_operation_done : opload_operation_done;
      other_v = st ? opload_operation_done : opstore_operation_done;
      check("other_done", 64'(other_v), 64'd0);
      check("busy_ready", 64'({opstore_index_ready, opload_index_ready}), 64'd0);
      if (done_v) begin
        seen = 1'b1;
      end else begin
        check_hold();
        @(negedge clock);
        k++;
      end
    end
    if (!seen) begin
      check(st ? "store_done_timeout" : "load_done_timeout", 64'd0, 64'd1);
    end else begin
      check(st ? "store_latency" : "load_latency", 64'(k), 64'(LATENCY + 1));
      if (st) begin
        exp_store_cnt++;
      end else begin
        exp_load_cnt++;
        if (exp_q.size() == 0) begin
          check("load_unexpected", 64'd1, 64'd0);
        end else begin
          rdata_exp = exp_q.pop_front();
          check("load_data", opload_read_data, rdata_exp);
        end
      end
    end
    @(negedge clock);
    check("idle_ready", 64'({opstore_index_ready, opload_index_ready}), 64'd3);
    check("idle_done", 64'({opstore_operation_done, opload_operation_done}), 64'd0);
    check_hold();
  endtask

  // Assert reset at the current time, check reset values, release at a falling edge.
  task automatic do_reset();
    reset_n             = 1'b0;
    opstore_index_valid = 1'b0;
    opload_index_valid  = 1'b0;
    rdata_exp           = '0;
    exp_q.delete();
    exp_store_cnt       = 0;
    exp_load_cnt        = 0;
    #1;
    check("rst_ready", 64'({opstore_index_ready, opload_index_ready}), 64'd3);
    check("rst_done", 64'({opstore_operation_done, opload_operation_done}), 64'd0);
    check("rst_rdata", opload_read_data, 64'd0);
    check_stats();
    repeat (3) begin
      @(negedge clock);
      check("rst_hold_done", 64'({opstore_operation_done, opload_operation_done}), 64'd0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_ready", 64'({opstore_index_ready, opload_index_ready}), 64'd3);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    #2;
    do_reset();

    // Give a known value to every word the test touches. Word 7 is zero.
    for (int i = 0; i < 16; i++) begin
      start_store(19'(i), '1, (i == 7) ? 64'd0 : rand64());
      finish_op(1'b1);
    end

    // Full-mask store followed by a load of the same word.
    start_store(19'd5, '1, 64'h1122334455667788);
    finish_op(1'b1);
    start_load(19'd5);
    finish_op(1'b0);
    check("load5_value", opload_read_data, 64'h1122334455667788);
    repeat (3) begin
      @(negedge clock);
      check_hold();
    end

    // Low-half masked store over that word.
    start_store(19'd5, 64'h00000000FFFFFFFF, 64'hAAAAAAAABBBBBBBB);
    finish_op(1'b1);
    start_load(19'd5);
    finish_op(1'b0);
    check("masked_value", opload_read_data, 64'h11223344BBBBBBBB);

    // Store and load offered together: store completes first, load sees it.
    start_store(19'd9, '1, 64'hCAFEF00D12345678);
    start_load(19'd9);
    finish_op(1'b1);
    finish_op(1'b0);
    check("dual_value", opload_read_data, 64'hCAFEF00D12345678);

    // Zero mask leaves the word unchanged.
    start_store(19'd3, 64'd0, rand64());
    finish_op(1'b1);
    start_load(19'd3);
    finish_op(1'b0);

    // High index bits alias onto the low word.
    start_load(19'h00405);
    finish_op(1'b0);
    check("alias_value", opload_read_data, 64'h11223344BBBBBBBB);
    start_store(19'h7FC03, '1, 64'h0F0F0F0F0F0F0F0F);
    finish_op(1'b1);
    start_load(19'd3);
    finish_op(1'b0);

    // Randomized traffic over 16 words with random aliasing high bits.
    for (int n = 0; n < 80; n++) begin
      logic [18:0] idx;
      logic [18:0] idx2;
      logic [63:0] m;
      int          kind;
      kind = $urandom_range(0, 3);
      idx  = {9'($urandom_range(0, 511)), 10'($urandom_range(0, 15))};
      idx2 = {9'($urandom_range(0, 511)), 10'($urandom_range(0, 15))};
      case ($urandom_range(0, 3))
        0:       m = '1;
        1:       m = '0;
        2:       m = rand64();
        default: m = 64'h00000000FFFFFFFF;
      endcase
      if (kind <= 1) begin
        start_store(idx, m, rand64());
        finish_op(1'b1);
      end else if (kind == 2) begin
        start_load(idx);
        finish_op(1'b0);
      end else begin
        start_store(idx, m, rand64());
        start_load(idx2);
        finish_op(1'b1);
        finish_op(1'b0);
      end
    end
    check_stats();

    // A reset during BUSY aborts a store: no done pulse, word 7 keeps zero.
    start_store(19'd7, '1, 64'd0);
    finish_op(1'b1);
    opstore_index_valid = 1'b1;
    opstore_index       = 19'd7;
    opstore_write_mask  = '1;
    opstore_write_data  = '1;
    @(posedge clock);
    @(negedge clock);
    opstore_index_valid = 1'b0;
    check("abort_busy_ready", 64'({opstore_index_ready, opload_index_ready}), 64'd0);
    do_reset();
    repeat (3) begin
      @(negedge clock);
      check("abort_no_done", 64'({opstore_operation_done, opload_operation_done}), 64'd0);
    end
    start_load(19'd7);
    finish_op(1'b0);
    check("abort_value", opload_read_data, 64'd0);

    // A few transactions after reset so the counters restart from zero.
    start_store(19'd11, rand64(), rand64());
    finish_op(1'b1);
    start_load(19'd11);
    finish_op(1'b0);
    check_stats();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
